// File: rtl/hazard_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_if : pipeline-side signals seen by the hazard sequencer     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       mem_rd;
  logic             mem_reg_write;
  logic             branch_taken;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Pipeline datapath side
  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble,
    input  fwd_a, fwd_b, stall_count, flush_count
  );

  // Hazard sequencer side
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write, branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble,
    output fwd_a, fwd_b, stall_count, flush_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_sequencer : load-use stall, branch flush and forwarding     |
// | control for a 5-stage RV32I pipeline. Rev 1.0                      |
// +--------------------------------------------------------------------+
module hazard_sequencer #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz_if
);

  localparam int WAIT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = (MEM_WAIT > 0) ? WAIT_W'(MEM_WAIT - 1) : '0;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [0:0] {
    ST_RUN       = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        fwd_a_q, fwd_a_d;
  logic [1:0]        fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic w_ex_load;
  logic w_hz;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_ifid_flush;
  logic w_idex_bubble;

  function automatic logic [1:0] fwd_sel(
    input logic       use_rs,
    input logic [4:0] rs,
    input logic       ex_wr,
    input logic [4:0] ex_rd,
    input logic       mem_wr,
    input logic [4:0] mem_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    // The younger EX result wins over MEM; x0 is hardwired and never forwards
    if (use_rs && ex_wr && (ex_rd != 5'd0) && (ex_rd == rs)) begin
      sel = 2'b01;
    end else if (use_rs && mem_wr && (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  assign w_ex_load = hz_if.id_valid & hz_if.ex_mem_read & hz_if.ex_reg_write
                   & (hz_if.ex_rd != 5'd0);
  assign w_hz      = w_ex_load
                   & ((hz_if.id_use_rs1 & (hz_if.id_rs1 == hz_if.ex_rd))
                    | (hz_if.id_use_rs2 & (hz_if.id_rs2 == hz_if.ex_rd)));

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;

    if (hz_if.branch_taken) begin
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      wait_d        = '0;
      state_d       = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (w_hz) begin
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
            if (MEM_WAIT != 0) begin
              wait_d  = WAIT_INIT;
              state_d = ST_LOAD_WAIT;
            end
          end
        end
        ST_LOAD_WAIT: begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
          if (wait_q != '0) begin
            wait_d = wait_q - WAIT_W'(1);
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_comb begin
    fwd_a_d     = 2'b00;
    fwd_b_d     = 2'b00;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    if (!w_idex_bubble) begin
      fwd_a_d = fwd_sel(hz_if.id_use_rs1, hz_if.id_rs1, hz_if.ex_reg_write,
                        hz_if.ex_rd, hz_if.mem_reg_write, hz_if.mem_rd);
      fwd_b_d = fwd_sel(hz_if.id_use_rs2, hz_if.id_rs2, hz_if.ex_reg_write,
                        hz_if.ex_rd, hz_if.mem_reg_write, hz_if.mem_rd);
    end
    if (!w_pc_write && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (hz_if.branch_taken && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      fwd_a_q     <= 2'b00;
      fwd_b_q     <= 2'b00;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // While in reset the pipeline is frozen and fed NOPs regardless of state
  assign hz_if.pc_write    = rst_n & w_pc_write;
  assign hz_if.ifid_write  = rst_n & w_ifid_write;
  assign hz_if.ifid_flush  = ~rst_n | w_ifid_flush;
  assign hz_if.idex_bubble = ~rst_n | w_idex_bubble;
  assign hz_if.fwd_a       = fwd_a_q;
  assign hz_if.fwd_b       = fwd_b_q;
  assign hz_if.stall_count = stall_cnt_q;
  assign hz_if.flush_count = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_hazard_sequencer : two sequencer instances (MEM_WAIT 0 / 2)     |
// | against a cycle-level reference model. Rev 1.0                     |
// +--------------------------------------------------------------------+
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid, id_use_rs1, id_use_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, branch_taken;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_if #(.CNT_W(16)) if0 ();
  hazard_if #(.CNT_W(2))  if1 ();

  assign if0.id_valid = id_valid;           assign if1.id_valid = id_valid;
  assign if0.id_rs1 = id_rs1;               assign if1.id_rs1 = id_rs1;
  assign if0.id_rs2 = id_rs2;               assign if1.id_rs2 = id_rs2;
  assign if0.id_use_rs1 = id_use_rs1;       assign if1.id_use_rs1 = id_use_rs1;
  assign if0.id_use_rs2 = id_use_rs2;       assign if1.id_use_rs2 = id_use_rs2;
  assign if0.ex_rd = ex_rd;                 assign if1.ex_rd = ex_rd;
  assign if0.ex_reg_write = ex_reg_write;   assign if1.ex_reg_write = ex_reg_write;
  assign if0.ex_mem_read = ex_mem_read;     assign if1.ex_mem_read = ex_mem_read;
  assign if0.mem_rd = mem_rd;               assign if1.mem_rd = mem_rd;
  assign if0.mem_reg_write = mem_reg_write; assign if1.mem_reg_write = mem_reg_write;
  assign if0.branch_taken = branch_taken;   assign if1.branch_taken = branch_taken;

  hazard_sequencer #(.MEM_WAIT(0), .CNT_W(16)) u0 (.clk(clk), .rst_n(rst_n), .hz_if(if0));
  hazard_sequencer #(.MEM_WAIT(2), .CNT_W(2))  u1 (.clk(clk), .rst_n(rst_n), .hz_if(if1));

  // {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b, stall16, flush16}
  logic [39:0] obs [2];
  assign obs[0] = {if0.pc_write, if0.ifid_write, if0.ifid_flush, if0.idex_bubble,
                   if0.fwd_a, if0.fwd_b, if0.stall_count, if0.flush_count};
  assign obs[1] = {if1.pc_write, if1.ifid_write, if1.ifid_flush, if1.idex_bubble,
                   if1.fwd_a, if1.fwd_b, 14'd0, if1.stall_count, 14'd0, if1.flush_count};

  // Reference model: stall_left counts remaining memory-wait stall cycles
  int         MW   [2] = '{0, 2};
  int         MAXC [2] = '{65535, 3};
  int         stall_left [2];
  int         m_stall [2];
  int         m_flush [2];
  logic [1:0] m_fa [2];
  logic [1:0] m_fb [2];

  function automatic bit hz_now();
    return id_valid && ex_mem_read && ex_reg_write && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  function automatic logic [3:0] exp_ctl(int k);
    if (!rst_n)                        return 4'b0011;
    if (branch_taken)                  return 4'b1111;
    if (stall_left[k] > 0 || hz_now()) return 4'b0001;
    return 4'b1100;
  endfunction

  function automatic logic [1:0] exp_sel(bit use_r, logic [4:0] rs);
    if (use_r && ex_reg_write && ex_rd != 0 && ex_rd == rs)    return 2'b01;
    if (use_r && mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [39:0] exp_vec(int k);
    return {exp_ctl(k), m_fa[k], m_fb[k], 16'(m_stall[k]), 16'(m_flush[k])};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      stall_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_fa[k] = 2'b00; m_fb[k] = 2'b00;
    end
  endtask

  task automatic model_edge();
    logic [3:0] c;
    bit         hz;
    hz = hz_now();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        stall_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_fa[k] = 2'b00; m_fb[k] = 2'b00;
      end else begin
        c = exp_ctl(k);
        if (!c[3] && m_stall[k] < MAXC[k]) m_stall[k]++;
        if (branch_taken && m_flush[k] < MAXC[k]) m_flush[k]++;
        m_fa[k] = c[0] ? 2'b00 : exp_sel(id_use_rs1, id_rs1);
        m_fb[k] = c[0] ? 2'b00 : exp_sel(id_use_rs2, id_rs2);
        if (branch_taken)           stall_left[k] = 0;
        else if (stall_left[k] > 0) stall_left[k]--;
        else if (hz)                stall_left[k] = MW[k];
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic set_load_use(logic [4:0] rd, bit on_rs2);
    set_idle();
    id_valid = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    id_rs1 = on_rs2 ? 5'd1 : rd;
    id_rs2 = on_rs2 ? rd : 5'd1;
    ex_rd = rd; ex_reg_write = 1'b1; ex_mem_read = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    set_idle();
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    model_clear();
    #2;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        errors++; $display("FAIL reset_state u%0d got %h want %h", k, obs[k], exp_vec(k));
      end
    end
    checks++;
    if (obs[0][39:36] !== 4'b0011) begin
      errors++; $display("FAIL reset_forced_ctl got %b want 0011", obs[0][39:36]);
    end
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    apply_reset();
    for (int cyc = 0; cyc < 3; cyc++) begin
      if (cyc == 0) set_load_use(5'd5, 1'b0);
      else begin
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = 5'd5; mem_reg_write = 1'b1;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++; $display("FAIL load_use c%0d u%0d got %h want %h", cyc, k, obs[k], exp_vec(k));
        end
      end
      if (cyc < 2) begin
        checks++;
        if ({if0.pc_write, if0.idex_bubble} !== ((cyc == 0) ? 2'b01 : 2'b10)) begin
          errors++; $display("FAIL load_use_stall c%0d got %b", cyc, {if0.pc_write, if0.idex_bubble});
        end
      end
      if (cyc == 2) begin
        checks++;
        if ({if0.fwd_a, if0.stall_count} !== {2'b10, 16'd1}) begin
          errors++; $display("FAIL load_use_fwd got fwd_a=%b stall=%0d want 10/1", if0.fwd_a, if0.stall_count);
        end
      end
      if (cyc < 2) advance();
    end
  endtask

  task automatic test_load_wait();
    int nstall;
    nstall = 0;
    apply_reset();
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc == 0) set_load_use(5'd7, 1'b1);
      else begin
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = 5'd7; mem_reg_write = 1'b1;
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++; $display("FAIL load_wait c%0d u%0d got %h want %h", cyc, k, obs[k], exp_vec(k));
        end
      end
      if (!if1.pc_write) nstall++;
      advance();
    end
    checks++;
    if (nstall != 3 || if1.stall_count !== 2'd3) begin
      errors++; $display("FAIL load_wait_len got %0d cycles cnt=%0d want 3/3", nstall, if1.stall_count);
    end
  endtask

  task automatic test_branch_in_wait();
    apply_reset();
    for (int cyc = 0; cyc < 3; cyc++) begin
      set_idle();
      if (cyc == 0) set_load_use(5'd9, 1'b0);
      if (cyc == 1) branch_taken = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++; $display("FAIL branch_wait c%0d u%0d got %h want %h", cyc, k, obs[k], exp_vec(k));
        end
      end
      if (cyc == 1) begin
        checks++;
        if ({if1.pc_write, if1.ifid_flush, if1.idex_bubble} !== 3'b111) begin
          errors++; $display("FAIL branch_wait_flush got %b want 111", {if1.pc_write, if1.ifid_flush, if1.idex_bubble});
        end
      end
      if (cyc == 2) begin
        checks++;
        if ({if1.pc_write, if1.flush_count} !== {1'b1, 2'd1}) begin
          errors++; $display("FAIL branch_wait_run got pc=%b flush=%0d want 1/1", if1.pc_write, if1.flush_count);
        end
      end
      advance();
    end
  endtask

  task automatic test_forward();
    apply_reset();
    for (int cyc = 0; cyc < 2; cyc++) begin
      set_idle();
      id_valid = 1'b1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
      ex_reg_write = 1'b1; mem_reg_write = 1'b1;
      id_rs1 = (cyc == 0) ? 5'd3 : 5'd0; id_rs2 = id_rs1;
      ex_rd = id_rs1; mem_rd = id_rs1;
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++; $display("FAIL forward c%0d u%0d got %h want %h", cyc, k, obs[k], exp_vec(k));
        end
      end
      advance();
      checks++;
      if ({if0.fwd_a, if0.fwd_b} !== ((cyc == 0) ? 4'b0101 : 4'b0000)) begin
        errors++; $display("FAIL forward_sel c%0d got %b", cyc, {if0.fwd_a, if0.fwd_b});
      end
    end
  endtask

  task automatic test_x0_load();
    apply_reset();
    set_load_use(5'd0, 1'b0);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k)) begin
        errors++; $display("FAIL x0_load u%0d got %h want %h", k, obs[k], exp_vec(k));
      end
    end
    checks++;
    if ({if0.pc_write, if1.pc_write} !== 2'b11) begin
      errors++; $display("FAIL x0_no_stall got %b want 11", {if0.pc_write, if1.pc_write});
    end
    advance();
  endtask

  task automatic test_saturate_and_reset();
    apply_reset();
    set_idle();
    branch_taken = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++; $display("FAIL saturate c%0d u%0d got %h want %h", cyc, k, obs[k], exp_vec(k));
        end
      end
      advance();
    end
    checks++;
    if ({if1.flush_count, if0.flush_count} !== {2'd3, 16'd5}) begin
      errors++; $display("FAIL flush_sat got u1=%0d u0=%0d want 3/5", if1.flush_count, if0.flush_count);
    end
    set_load_use(5'd4, 1'b0);
    advance();
    set_idle();
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (obs[1] !== {4'b0011, 36'd0}) begin
      errors++; $display("FAIL reset_mid_stall got %h want %h", obs[1], {4'b0011, 36'd0});
    end
    advance();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== exp_vec(k) || obs[k][39] !== 1'b1) begin
        errors++; $display("FAIL reset_release u%0d got %h want %h", k, obs[k], exp_vec(k));
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      id_valid      = ($urandom_range(0, 7) != 0);
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_use_rs1    = 1'($urandom_range(0, 1));
      id_use_rs2    = 1'($urandom_range(0, 1));
      ex_rd         = 5'($urandom_range(0, 3));
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_mem_read   = 1'($urandom_range(0, 1));
      mem_rd        = 5'($urandom_range(0, 3));
      mem_reg_write = 1'($urandom_range(0, 1));
      branch_taken  = ($urandom_range(0, 7) == 0);
      #1;
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_vec(k)) begin
          errors++; $display("FAIL random c%0d u%0d got %h want %h", cyc, k, obs[k], exp_vec(k));
        end
      end
      advance();
    end
  endtask

  initial begin
    set_idle();
    model_clear();
    test_reset();
    test_load_use();
    test_load_wait();
    test_branch_in_wait();
    test_forward();
    test_x0_load();
    test_saturate_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
